// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with programmable bit period and optional parity (macro UART_TX_PARITY_EN)
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t                state_q;
    logic [4:0]            cnt_q;
    logic [4:0]            presc_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  tx_q;
    logic                  busy_q;
    logic [4:0]            presc_d;
    logic [BW-1:0]         bit_d;
    logic                  bit_done;
    logic                  last_bit;
`ifdef UART_TX_PARITY_EN
    logic                  par_en_q;
    logic                  par_typ_q;
`else
    logic                  unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif
    assign presc_d  = Prescale < 5'd4 ? 5'd4 : Prescale;
    assign bit_done = cnt_q == presc_q - 5'd1;
    assign last_bit = bit_q == BW'(DATA_WIDTH - 1);
    assign bit_d    = bit_q + 1'b1;
    assign TX_OUT   = tx_q;
    assign busy     = busy_q;
    // Frame sequencer: every bit lasts presc_q cycles, the counter reloads at each bit boundary
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (Data_Valid) begin
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        data_q    <= P_DATA;
                        presc_q   <= presc_d;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= data_q[0];
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state_q <= PARITY;
                                tx_q    <= (^data_q) ^ par_typ_q;
                            end else
`endif
                            begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_d;
                            tx_q  <= data_q[bit_d];
                        end
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state_q <= STOP;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of payload bits per frame.
REQ-002 Port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous and active-high.
REQ-004 Port: P_DATA  input  DATA_WIDTH  parallel payload, sampled only on acceptance.
REQ-005 Port: Data_Valid  input  1  request to send P_DATA.
REQ-006 Port: PAR_EN  input  1  1 = append parity bit, sampled only on acceptance.
REQ-007 Port: PAR_TYP  input  1  0 = even, 1 = odd parity, sampled only on acceptance.
REQ-008 Port: Prescale  input  5  CLK cycles per bit, sampled only on acceptance.
REQ-009 Port: TX_OUT  output  1  serial line, registered, idle high.
REQ-010 Port: busy  output  1  registered, high while a frame is in progress.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; the encoding is free.
REQ-012 Acceptance SHALL occur on an edge where state = IDLE and Data_Valid = 1; Data_Valid in any other state SHALL be ignored, with no queueing.
REQ-013 On acceptance, P_DATA, PAR_EN, PAR_TYP and the effective prescale SHALL be latched; changes on these inputs during the frame SHALL have no effect.
REQ-014 Effective prescale SHALL be Prescale if Prescale >= 4, else 4.
REQ-015 Latency: on the cycle after acceptance, state SHALL be START, TX_OUT = 0, busy = 1.
REQ-016 Each bit SHALL be held on TX_OUT for exactly the effective-prescale number of CLK cycles, timed by an edge counter that reloads at each bit boundary.
REQ-017 DATA SHALL transmit DATA_WIDTH bits LSB first, with a bit counter from 0 to DATA_WIDTH-1.
REQ-018 Parity bit SHALL be the XOR of the latched data for even parity, and its inverse for odd parity, computed from latched data.
REQ-019 Transitions: START->DATA; DATA (last bit done)->PARITY if latched PAR_EN, else STOP; PARITY->STOP; STOP (done)->IDLE.
REQ-020 STOP SHALL drive TX_OUT = 1 for one bit period.
REQ-021 On the cycle after STOP completes, state SHALL be IDLE, busy = 0 and TX_OUT = 1; the earliest next acceptance SHALL be that cycle, giving a minimum of one idle CLK cycle between frames.
REQ-022 Frame length SHALL be (DATA_WIDTH+2+PAR) x effective-prescale cycles of busy = 1, where PAR = 1 if parity is sent, else 0.
REQ-023 In IDLE, TX_OUT SHALL be 1 and busy SHALL be 0.

Reset
REQ-024 When RST = 1 at a rising edge, the following SHALL hold on the next cycle, regardless of state: state = IDLE, TX_OUT = 1, busy = 0, all counters = 0, latched data = 0.
REQ-025 A Data_Valid asserted on the same edge as RST SHALL be dropped.
REQ-026 A frame interrupted by reset SHALL NOT resume.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, the PARITY state and parity logic SHALL be compiled in and behave per REQ-018/019.
REQ-028 When UART_TX_PARITY_EN is undefined, PAR_EN and PAR_TYP SHALL be ignored, DATA SHALL go directly to STOP, and the frame SHALL be DATA_WIDTH+2 bits.

Verification
REQ-029 Prescale=8, P_DATA=0xA5, PAR_EN=0, pulse Data_Valid -> TX_OUT bits 0,1,0,1,0,0,1,0,1,1, 8 cycles each, busy high exactly 80 cycles, then TX_OUT=1 and busy=0.
REQ-030 Prescale=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 then 1 -> parity bit 0 then 1, busy high 88 cycles each frame.
REQ-031 Mid-frame, change P_DATA to 0x3C and pulse Data_Valid -> current 0xA5 frame unchanged, second request not sent.
REQ-032 Prescale=2 -> every bit held 4 cycles; Prescale=31 -> every bit held 31 cycles.
REQ-033 Assert RST during DATA bit 3 -> next cycle TX_OUT=1 and busy=0; a new Data_Valid then starts a full fresh frame.
REQ-034 Data_Valid held high continuously -> frames back-to-back, with exactly one idle cycle (TX_OUT=1, busy=0) between them.
